sram_controller: RTL and testbench

Initiator-side controller for the 32-bit external SRAM in the processor's memory stage. Accepts single-word read/write requests from the MEM stage and converts byte addresses to SRAM word addresses. Drives the SRAM bus (SRAM_ADDR, SRAM_WE_N, bidirectional SRAM_DQ) for a fixed number of wait states. Holds `ready` low while an access is in flight so the pipeline freezes.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_wait_counter.sv | 33 +++
 rtl/sram_controller.sv | 139 +++++++++++++
 tb/tb_sram_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the external SRAM controller.
package sram_pkg;

    localparam int SRAM_ADDR_W    = 17;
    localparam int SRAM_DATA_W    = 32;
    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_CNT_W     = 4;    // wait states are 1..15

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Byte address -> SRAM word address; addresses below base wrap modulo 2^17 words.
    function automatic logic [SRAM_ADDR_W-1:0] byte_to_word(input logic [31:0] addr,
                                                            input logic [31:0] base);
        return SRAM_ADDR_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: clears in IDLE, counts during ACCESS, flags the last bus cycle.
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [SRAM_CNT_W-1:0] TC_VAL = SRAM_CNT_W'(WAIT_CYCLES - 1);

    logic [SRAM_CNT_W-1:0] count_q, count_d;

    // Clear has priority so a fresh transfer always starts at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i)     count_d = '0;
        else if (en_i) count_d = count_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: one word per request, fixed wait states,
// ready held low while a transfer is in flight.
// Optional: define SRAM_READ_BYPASS_EN to skip the bus for a repeat read
// of the last completed read address.
module sram_controller
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

    state_t                 state_q, state_d;
    logic                   op_wr_q, op_wr_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
    logic                   cnt_clr, cnt_en, cnt_tc;
    logic                   req;
    logic [SRAM_ADDR_W-1:0] req_word;
    logic                   wr_active;

`ifdef SRAM_READ_BYPASS_EN
    logic [SRAM_ADDR_W-1:0] tag_q, tag_d;
    logic                   tag_vld_q, tag_vld_d;
`endif

    assign req      = rd_en | wr_en;
    assign req_word = byte_to_word(address, 32'(BASE_ADDR));

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state, latching and ready; inputs are only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        ready   = 1'b0;
`ifdef SRAM_READ_BYPASS_EN
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
`endif
        case (state_q)
            IDLE: begin
                ready   = ~req;
                cnt_clr = 1'b1;
                if (req) begin
                    op_wr_d = wr_en;          // both asserted -> write
                    addr_d  = req_word;
                    wdata_d = write_data;
                    state_d = ACCESS;
`ifdef SRAM_READ_BYPASS_EN
                    if (wr_en)
                        tag_vld_d = 1'b0;
                    else if (tag_vld_q && (tag_q == req_word))
                        state_d = DONE;       // hit: read_data already holds this word
`endif
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    if (!op_wr_q) begin
                        rdata_d = SRAM_DQ;
`ifdef SRAM_READ_BYPASS_EN
                        tag_d     = addr_q;
                        tag_vld_d = 1'b1;
`endif
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SRAM_READ_BYPASS_EN
    // Last-read tag; any write or reset invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`endif

    // Bus outputs decode straight from state so reset releases them at once.
    assign wr_active = (state_q == ACCESS) && op_wr_q;
    assign SRAM_ADDR = (state_q == ACCESS) ? addr_q : '0;
    assign SRAM_WE_N = ~wr_active;
    assign SRAM_DQ   = wr_active ? wdata_q : {SRAM_DATA_W{1'bz}};
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a small SRAM model on the bus.
// Build with +define+SRAM_READ_BYPASS_EN to also exercise the read bypass.
module tb_sram_controller;

    localparam int WC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [16:0] SRAM_ADDR;
    wire         SRAM_WE_N;
    wire  [31:0] dq;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem    [0:7];   // SRAM model, aliased on low word-address bits
    logic [31:0] shadow [0:7];   // what the bench expects the SRAM to hold
    logic [31:0] exp_q [$];      // expected read results
    logic [31:0] hold_rd;        // expected current read_data value
    logic [31:0] mdl_rd;

    sram_controller #(.WAIT_CYCLES(WC), .BASE_ADDR(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_DQ    (dq)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever it is not being written.
    assign mdl_rd = mem[SRAM_ADDR[2:0]];
    assign dq     = SRAM_WE_N ? mdl_rd : 32'bz;
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[2:0]] <= dq;

    function automatic logic [16:0] wa(input logic [31:0] a);
        logic [31:0] t;
        t = a - 32'd1024;
        return t[18:2];
    endfunction

    task automatic start(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
    endtask

    task automatic drop();
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Observe one transfer from its request cycle up to the cycle ready rises.
    task automatic run_xfer(input logic [16:0] exp_addr, input logic [31:0] exp_dq,
                            output int low, output int we_low, output int addr_bad,
                            output int bus, output int dq_bad, output logic [31:0] rd,
                            output bit tmo);
        low = 0; we_low = 0; addr_bad = 0; bus = 0; dq_bad = 0; rd = '0; tmo = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!SRAM_WE_N || SRAM_ADDR != 0) bus++;
            if (!SRAM_WE_N) begin
                we_low++;
                if (dq !== exp_dq) dq_bad++;
            end else if (dq !== mdl_rd) dq_bad++;
            if (SRAM_ADDR != 0 && SRAM_ADDR !== exp_addr) addr_bad++;
            if (ready) begin rd = read_data; tmo = 1'b0; break; end
            low++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (ready !== 1'b1)      begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
        total++; if (SRAM_WE_N !== 1'b1)  begin bad++; $display("FAIL rst_we_n got=%b want=1", SRAM_WE_N); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", read_data); end
        total++; if (SRAM_ADDR !== 17'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", SRAM_ADDR); end
        total++; if (dq !== mdl_rd)       begin bad++; $display("FAIL rst_dq_released got=%h want=%h", dq, mdl_rd); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1)      begin bad++; $display("FAIL idle_ready got=%b want=1", ready); end
    endtask

    task automatic test_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        int low, we_low, addr_bad, bus, dq_bad; logic [31:0] rd; bit tmo;
        shadow[wa(a) & 17'h7] = d;
        start(1'b1, both, a, d);
        run_xfer(wa(a), d, low, we_low, addr_bad, bus, dq_bad, rd, tmo);
        drop();
        total++; if (tmo)            begin bad++; $display("FAIL wr_timeout addr=%h got=no_ready want=ready", a); end
        total++; if (low != WC + 1)  begin bad++; $display("FAIL wr_ready_low addr=%h got=%0d want=%0d", a, low, WC + 1); end
        total++; if (we_low != WC)   begin bad++; $display("FAIL wr_we_low addr=%h got=%0d want=%0d", a, we_low, WC); end
        total++; if (addr_bad != 0)  begin bad++; $display("FAIL wr_sram_addr addr=%h got=%0d_bad want=0", a, addr_bad); end
        total++; if (dq_bad != 0)    begin bad++; $display("FAIL wr_dq addr=%h got=%0d_bad want=0", a, dq_bad); end
        total++; if (rd !== hold_rd) begin bad++; $display("FAIL wr_rdata_hold got=%h want=%h", rd, hold_rd); end
    endtask

    task automatic test_read(input logic [31:0] a, input int exp_low, input int exp_bus);
        int low, we_low, addr_bad, bus, dq_bad; logic [31:0] rd, exp; bit tmo;
        exp_q.push_back(shadow[wa(a) & 17'h7]);
        start(1'b0, 1'b1, a, 32'h0);
        run_xfer(wa(a), 32'h0, low, we_low, addr_bad, bus, dq_bad, rd, tmo);
        drop();
        exp = exp_q.pop_front();
        hold_rd = exp;
        total++; if (tmo)            begin bad++; $display("FAIL rd_timeout addr=%h got=no_ready want=ready", a); end
        total++; if (rd !== exp)     begin bad++; $display("FAIL rd_data addr=%h got=%h want=%h", a, rd, exp); end
        total++; if (low != exp_low) begin bad++; $display("FAIL rd_ready_low addr=%h got=%0d want=%0d", a, low, exp_low); end
        total++; if (we_low != 0)    begin bad++; $display("FAIL rd_we_n addr=%h got=%0d_low want=0", a, we_low); end
        total++; if (bus != exp_bus) begin bad++; $display("FAIL rd_bus_cycles addr=%h got=%0d want=%0d", a, bus, exp_bus); end
        total++; if (dq_bad != 0 || addr_bad != 0)
                     begin bad++; $display("FAIL rd_bus addr=%h got=%0d/%0d_bad want=0/0", a, dq_bad, addr_bad); end
    endtask

    task automatic test_back_to_back();
        int low, we_low, addr_bad, bus, dq_bad; logic [31:0] rd; bit tmo;
        shadow[wa(32'd1040) & 17'h7] = 32'h0BADF00D;
        start(1'b1, 1'b0, 32'd1040, 32'h0BADF00D);
        for (int n = 0; n < 2; n++) begin
            run_xfer(wa(32'd1040), 32'h0BADF00D, low, we_low, addr_bad, bus, dq_bad, rd, tmo);
            total++; if (tmo || low + 1 != WC + 2)
                begin bad++; $display("FAIL b2b_spacing xfer=%0d got=%0d want=%0d", n, low + 1, WC + 2); end
            total++; if (we_low != WC)
                begin bad++; $display("FAIL b2b_we_low xfer=%0d got=%0d want=%0d", n, we_low, WC); end
        end
        drop();
        @(negedge clk);
        total++; if (ready !== 1'b1 || SRAM_WE_N !== 1'b1)
            begin bad++; $display("FAIL b2b_idle got=%b%b want=11", ready, SRAM_WE_N); end
    endtask

    task automatic test_reset_mid_write();
        start(1'b1, 1'b0, 32'd1044, 32'hCAFEF00D);
        repeat (4) @(negedge clk);   // request cycle, then ACCESS cycles 1..3
        total++; if (SRAM_WE_N !== 1'b0) begin bad++; $display("FAIL mid_we_active got=%b want=0", SRAM_WE_N); end
        #1 rst = 1'b1; wr_en = 1'b0;
        #1;
        total++; if (SRAM_WE_N !== 1'b1)  begin bad++; $display("FAIL mid_we_n got=%b want=1", SRAM_WE_N); end
        total++; if (SRAM_ADDR !== 17'h0) begin bad++; $display("FAIL mid_addr got=%h want=0", SRAM_ADDR); end
        total++; if (dq !== mdl_rd)       begin bad++; $display("FAIL mid_dq_released got=%h want=%h", dq, mdl_rd); end
        total++; if (ready !== 1'b1)      begin bad++; $display("FAIL mid_ready got=%b want=1", ready); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h want=0", read_data); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b1 || SRAM_WE_N !== 1'b1)
            begin bad++; $display("FAIL mid_after_idle got=%b%b want=11", ready, SRAM_WE_N); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]    = 32'hA5A5_0000 + i;
            shadow[i] = 32'hA5A5_0000 + i;
        end
        hold_rd = '0;
        test_reset();
        test_write(32'd1028, 32'hDEADBEEF, 1'b0);
        test_read(32'd1028, WC + 1, WC);
        test_write(32'd1032, 32'h12345678, 1'b1);   // rd_en+wr_en -> write
        test_read(32'd1032, WC + 1, WC);
        test_back_to_back();
        test_write(32'd1020, 32'h5A5A1234, 1'b0);   // below base: word 0x1FFFF
        test_read(32'd1020, WC + 1, WC);
`ifdef SRAM_READ_BYPASS_EN
        test_read(32'd1028, WC + 1, WC);
        test_read(32'd1028, 1, 0);                  // tag hit: no bus activity
        test_write(32'd1036, 32'h0F0F0F0F, 1'b0);
        test_read(32'd1028, WC + 1, WC);
`endif
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
